tx_hex_formatter: RTL and testbench
===================================

Name: tx_hex_formatter

Overview:
Upstream feeder for the UART transmit path. Captures a binary word, converts it to ASCII hexadecimal characters (MSB nibble first), optionally appends CR LF, and pushes each character into the transmit block's input buffer. It drives the transmit block's byte input and rising-edge write strobe, and obeys the buffer-full back-pressure.

Parameters:
NIBBLES, 8, hex digits per word; captured word width is 4*NIBBLES.
BIT_PER_WORD, 7, MSB index of the character bus; bus width is BIT_PER_WORD+1. Must be ≥6.
UPPERCASE, 1, 1 selects 'A'-'F' (0x41-0x46); 0 selects 'a'-'f' (0x61-0x66).
APPEND_CRLF, 1, 1 appends 0x0D then 0x0A after the digits.
STROBE_CYCLES, 2, number of cycles data_clk is held high per character (≥1).
GAP_CYCLES, 4, low cycles after each strobe before busy_in is re-sampled (≥3).

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
value  in  4*NIBBLES  word to format
value_valid  in  1  capture request; honoured only when ready=1
ready  out  1  high in IDLE only
data_out  out  BIT_PER_WORD+1  ASCII character to transmit buffer
data_clk  out  1  write strobe to transmit buffer; the buffer writes on its rising edge
busy_in  in  1  transmit buffer full flag
done  out  1  one-cycle pulse after the last character's gap completes

Behaviour:
- All logic is clocked on posedge clk. rst is synchronous and active-high. It has priority over every other input.
- Reset values: state=IDLE, ready=1, data_out=0, data_clk=0, done=0, character index=0, internal counters=0.
- Total characters per word: N = NIBBLES + 2*APPEND_CRLF.
- Digit mapping: nibble 0-9 maps to 0x30+n. Nibble 10-15 maps to base+(n-10), where base is 0x41 or 0x61 per UPPERCASE. Bits above bit 6 of data_out are 0.
- States:
  - IDLE: ready=1. On value_valid=1, latch value into a shift register, set index=0, go to WAIT_SPACE. ready drops on the next cycle.
  - WAIT_SPACE: data_out is loaded with character[index] on entry and held. If busy_in=0, go to STROBE. Otherwise stay, for an unbounded time.
  - STROBE: data_clk=1 for exactly STROBE_CYCLES cycles, then go to GAP.
  - GAP: data_clk=0 for GAP_CYCLES cycles. At the end, if index=N-1, go to DONE. Otherwise increment index and go to WAIT_SPACE.
  - DONE: done=1 for one cycle, then go to IDLE.
- data_out is stable from WAIT_SPACE entry through the end of GAP. This covers the transmit block's registered edge detect and delayed buffer write.
- busy_in is sampled only in WAIT_SPACE. The gap guarantees the full flag reflects the preceding write before it is re-sampled.
- value_valid outside IDLE is ignored, with no queuing. value changes after capture have no effect.
- A value_valid in the same cycle as DONE is ignored. It is accepted in the following IDLE cycle.
- Minimum cycles per character with busy_in=0: 1 + STROBE_CYCLES + GAP_CYCLES.
- Reset mid-operation:
  - data_clk goes low at that edge.
  - No further strobes occur.
  - A partially sent word is abandoned.
  - done is not pulsed.

Test Plan:
- Reset with defaults, then value=0x1234ABCD with value_valid for 1 cycle, busy_in=0 -> data_out sequence 0x31,0x32,0x33,0x34,0x41,0x42,0x43,0x44,0x0D,0x0A. Exactly 10 data_clk rising edges, each high 2 cycles, spaced 7 cycles apart. One done pulse. ready returns high.
- UPPERCASE=0, APPEND_CRLF=0, NIBBLES=2, value=0xEF -> data_out 0x65 then 0x66. Exactly 2 strobes, then done.
- busy_in held high from cycle 0 for 50 cycles after capture -> data_clk stays 0 and data_out stays 0x31 throughout. The first strobe rises within 2 cycles of busy_in falling.
- busy_in asserted during GAP after the 3rd character, released 20 cycles later -> 4th character is strobed only after release. No character is lost or duplicated.
- value_valid pulsed again mid-transmission with value=0xFFFFFFFF -> ignored; the output sequence matches the first word only.
- rst asserted during the STROBE of the 5th character -> data_clk=0 and ready=1 after that edge, done never pulses. A new value=0x00000000 then produces eight 0x30 characters plus CR LF.

Source files
------------

// File: rtl/tx_hex_formatter.sv
// tx_hex_formatter: captures a binary word and feeds it, as ASCII hex digits
// (MSB nibble first, optional CR LF), into a UART transmit buffer using a
// rising-edge write strobe and the buffer-full back-pressure flag.
module tx_hex_formatter #(
    parameter int NIBBLES       = 8,
    parameter int BIT_PER_WORD  = 7,
    parameter int UPPERCASE     = 1,
    parameter int APPEND_CRLF   = 1,
    parameter int STROBE_CYCLES = 2,
    parameter int GAP_CYCLES    = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [4*NIBBLES-1:0]   value,
    input  logic                   value_valid,
    output logic                   ready,
    output logic [BIT_PER_WORD:0]  data_out,
    output logic                   data_clk,
    input  logic                   busy_in,
    output logic                   done
);

    localparam int WW     = 4 * NIBBLES;
    localparam int NCHARS = NIBBLES + 2 * APPEND_CRLF;
    localparam int IW     = (NCHARS > 1) ? $clog2(NCHARS) : 1;
    localparam int CMAX   = (STROBE_CYCLES > GAP_CYCLES) ? STROBE_CYCLES : GAP_CYCLES;
    localparam int CW     = $clog2(CMAX + 1);

    localparam logic [IW-1:0] LAST_IDX    = IW'(NCHARS - 1);
    localparam logic [CW-1:0] STROBE_LAST = CW'(STROBE_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST    = CW'(GAP_CYCLES - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WAIT   = 3'd1;
    localparam logic [2:0] S_STROBE = 3'd2;
    localparam logic [2:0] S_GAP    = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]            state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [WW-1:0]         shreg_q, shreg_d;
    logic [BIT_PER_WORD:0] data_out_q, data_out_d;
    logic                  data_clk_q, data_clk_d;
    logic                  ready_q, ready_d;
    logic                  done_q, done_d;

    logic [WW-1:0]         shifted;
    logic [IW-1:0]         idx_nx;

    // 7-bit ASCII for one hex digit
    function automatic logic [6:0] hex_char(input logic [3:0] n);
        if (n < 4'd10)
            return 7'h30 + {3'b000, n};
        else
            return ((UPPERCASE != 0) ? 7'h41 : 7'h61) + {3'b000, n - 4'd10};
    endfunction

    // Character at position idx: digits first, then CR and LF
    function automatic logic [BIT_PER_WORD:0] char_at(input logic [IW-1:0] idx,
                                                      input logic [3:0]    nib);
        logic [BIT_PER_WORD:0] r;
        r = '0;
        if (int'(idx) < NIBBLES)
            r[6:0] = hex_char(nib);
        else if (int'(idx) == NIBBLES)
            r[6:0] = 7'h0D;
        else
            r[6:0] = 7'h0A;
        return r;
    endfunction

    // Next-state logic: sequencer, character index, strobe/gap timer
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        shreg_d    = shreg_q;
        data_out_d = data_out_q;
        shifted    = shreg_q << 4;
        idx_nx     = idx_q + 1'b1;

        case (state_q)
            S_IDLE: begin
                if (value_valid) begin
                    shreg_d    = value;
                    idx_d      = '0;
                    cnt_d      = '0;
                    // Character is loaded on WAIT entry so it is settled
                    // well before the first strobe edge.
                    data_out_d = char_at('0, value[WW-1 -: 4]);
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!busy_in) begin
                    cnt_d   = '0;
                    state_d = S_STROBE;
                end
            end
            S_STROBE: begin
                if (cnt_q == STROBE_LAST) begin
                    cnt_d   = '0;
                    state_d = S_GAP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d = '0;
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        // Shift so the next digit sits in the top nibble;
                        // zeros shifted in during CR/LF are never used.
                        idx_d      = idx_nx;
                        shreg_d    = shifted;
                        data_out_d = char_at(idx_nx, shifted[WW-1 -: 4]);
                        state_d    = S_WAIT;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        data_clk_d = (state_d == S_STROBE);
        ready_d    = (state_d == S_IDLE);
        done_d     = (state_d == S_DONE);
    end

    // State registers; reset drops the strobe immediately and abandons the word
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            cnt_q      <= '0;
            shreg_q    <= '0;
            data_out_q <= '0;
            data_clk_q <= 1'b0;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            shreg_q    <= shreg_d;
            data_out_q <= data_out_d;
            data_clk_q <= data_clk_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
        end
    end

    assign ready    = ready_q;
    assign data_out = data_out_q;
    assign data_clk = data_clk_q;
    assign done     = done_q;

endmodule

// File: tb/tb_tx_hex_formatter.sv
// Bench for tx_hex_formatter: scoreboard of expected characters checked on
// every data_clk rising edge, plus directed checks of reset, back-pressure,
// ignored captures and mid-word reset. A second instance covers lowercase,
// no CR LF, two nibbles.
module tb_tx_hex_formatter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] value = '0;
    logic        value_valid = 1'b0;
    logic        ready;
    logic [7:0]  data_out;
    logic        data_clk;
    logic        busy_in = 1'b0;
    logic        done;

    logic [7:0]  value2 = '0;
    logic        valid2 = 1'b0;
    logic        ready2;
    logic [7:0]  dout2;
    logic        dclk2;
    logic        busy2 = 1'b0;
    logic        done2;

    always #5 clk = ~clk;

    tx_hex_formatter u_dut (
        .clk(clk), .rst(rst), .value(value), .value_valid(value_valid),
        .ready(ready), .data_out(data_out), .data_clk(data_clk),
        .busy_in(busy_in), .done(done)
    );

    tx_hex_formatter #(.NIBBLES(2), .UPPERCASE(0), .APPEND_CRLF(0)) u_dut2 (
        .clk(clk), .rst(rst), .value(value2), .value_valid(valid2),
        .ready(ready2), .data_out(dout2), .data_clk(dclk2),
        .busy_in(busy2), .done(done2)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] exp_q[$];
    int  n_rise = 0;
    int  n_done = 0;
    bit  spacing_on = 1'b0;
    bit  have_prev = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Monitor: scoreboard pop on each strobe rise, strobe width, spacing, hold
    int         ncyc = 0;
    int         last_rise = 0;
    int         hi_len = 0;
    logic       dclk_prev = 1'b0;
    logic [7:0] rise_data = '0;
    always @(negedge clk) begin
        ncyc++;
        if (data_clk === 1'b1 && dclk_prev === 1'b0) begin
            n_rise++;
            hi_len    = 1;
            rise_data = data_out;
            check("strobe_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check("char", 32'(data_out), 32'(exp_q.pop_front()));
            if (spacing_on && have_prev) check("spacing", 32'(ncyc - last_rise), 32'd7);
            last_rise = ncyc;
            have_prev = 1'b1;
        end else if (data_clk === 1'b1) begin
            hi_len++;
        end else if (dclk_prev === 1'b1 && rst === 1'b0) begin
            check("strobe_width", 32'(hi_len), 32'd2);
            check("hold_after_strobe", 32'(data_out), 32'(rise_data));
        end
        if (done === 1'b1) n_done++;
        dclk_prev = data_clk;
    end

    task automatic push_word(input logic [31:0] w);
        string digits;
        logic [31:0] t;
        digits = "0123456789ABCDEF";
        t = w;
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(digits[int'(t[31:28])]);
            t = t << 4;
        end
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    task automatic capture(input logic [31:0] w, input logic [7:0] first);
        value = w;
        value_valid = 1'b1;
        @(negedge clk);
        value_valid = 1'b0;
        value = $urandom;
        check("ready_drops", 32'(ready), 32'd0);
        check("first_char_loaded", 32'(data_out), 32'(first));
    endtask

    task automatic wait_done(input string tag, input int max, input int rise_base);
        int k;
        k = 0;
        while (done !== 1'b1 && k < max) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_done"}, 32'(done), 32'd1);
        @(negedge clk);
        check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
        check({tag, "_ready_back"}, 32'(ready), 32'd1);
        check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_strobes"}, 32'(n_rise - rise_base), 32'd10);
    endtask

    task automatic wait_rises(input int target);
        int k;
        k = 0;
        while (n_rise < target && k < 300) begin
            @(negedge clk);
            k++;
        end
        check("reach_strobe", 32'(n_rise >= target), 32'd1);
    endtask

    initial begin
        int base, d0, nr, k;
        logic [7:0] got[2];
        bit   seen;
        logic prev;

        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_data_out", 32'(data_out), 32'd0);
        check("rst_data_clk", 32'(data_clk), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ready2", 32'(ready2), 32'd1);
        rst = 1'b0;
        @(negedge clk);

        // Basic word, free-running buffer
        base = n_rise; spacing_on = 1'b1; have_prev = 1'b0;
        d0 = n_done;
        push_word(32'h1234ABCD);
        capture(32'h1234ABCD, 8'h31);
        wait_done("basic", 200, base);
        check("basic_done_count", 32'(n_done - d0), 32'd1);

        // Capture request mid-word is ignored
        base = n_rise; have_prev = 1'b0;
        push_word(32'hDEADBEEF);
        capture(32'hDEADBEEF, 8'h44);
        repeat (15) @(negedge clk);
        value = 32'hFFFFFFFF; value_valid = 1'b1;
        @(negedge clk);
        value_valid = 1'b0;
        wait_done("ignore", 200, base);
        repeat (20) @(negedge clk);
        check("ignore_no_second_word", 32'(n_rise - base), 32'd10);

        // Buffer full from before capture
        base = n_rise; spacing_on = 1'b0; have_prev = 1'b0;
        busy_in = 1'b1;
        push_word(32'h1234ABCD);
        capture(32'h1234ABCD, 8'h31);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check("busy_no_strobe", 32'(data_clk), 32'd0);
            check("busy_hold_char", 32'(data_out), 32'h31);
        end
        busy_in = 1'b0;
        k = 0;
        while (data_clk !== 1'b1 && k < 2) begin
            @(negedge clk);
            k++;
        end
        check("busy_release_strobe", 32'(data_clk), 32'd1);
        wait_done("busy", 200, base);

        // Back-pressure raised in the gap after the 3rd character
        base = n_rise; have_prev = 1'b0;
        push_word(32'h0F5A9C3E);
        capture(32'h0F5A9C3E, 8'h30);
        wait_rises(base + 3);
        k = 0;
        while (data_clk !== 1'b0 && k < 10) begin
            @(negedge clk);
            k++;
        end
        busy_in = 1'b1;
        repeat (20) @(negedge clk);
        check("gap_busy_stalls", 32'(n_rise - base), 32'd3);
        busy_in = 1'b0;
        wait_done("gapbusy", 200, base);

        // Reset during the 5th strobe abandons the word
        base = n_rise; spacing_on = 1'b1; have_prev = 1'b0;
        push_word(32'h1234ABCD);
        capture(32'h1234ABCD, 8'h31);
        wait_rises(base + 5);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_data_clk", 32'(data_clk), 32'd0);
        check("midrst_ready", 32'(ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        d0 = n_done;
        repeat (30) @(negedge clk);
        check("midrst_no_done", 32'(n_done - d0), 32'd0);
        check("midrst_no_strobe", 32'(n_rise - base), 32'd5);
        base = n_rise; have_prev = 1'b0;
        push_word(32'h00000000);
        capture(32'h00000000, 8'h30);
        wait_done("after_rst", 200, base);

        // Lowercase, two nibbles, no CR LF
        value2 = 8'hEF; valid2 = 1'b1;
        @(negedge clk);
        valid2 = 1'b0;
        nr = 0; seen = 1'b0; prev = 1'b0;
        got[0] = '0; got[1] = '0;
        for (int i = 0; i < 40; i++) begin
            if (dclk2 === 1'b1 && prev === 1'b0) begin
                if (nr < 2) got[nr] = dout2;
                nr++;
            end
            prev = dclk2;
            if (done2 === 1'b1) seen = 1'b1;
            @(negedge clk);
        end
        check("lc_strobes", 32'(nr), 32'd2);
        check("lc_char0", 32'(got[0]), 32'h65);
        check("lc_char1", 32'(got[1]), 32'h66);
        check("lc_done", 32'(seen), 32'd1);
        check("lc_ready", 32'(ready2), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
